// File: rtl/ntt_agu_param.sv
// Parametrised NTT/INTT butterfly address generator; AGU_STALL_CNT_EN adds a stall_cnt output.
// Latency: first beat two cycles after start, then one beat per cycle.
// Backpressure: valid/ready output register; bus and counters hold while out_ready is low.
module ntt_agu_param #(
    parameter  int LOGN      = 16,
    parameter  int RADIX_LOG = 4,
    parameter  int D_WIDTH   = 16,
    localparam int R         = 1 << RADIX_LOG,
    localparam int K         = LOGN / RADIX_LOG,
    localparam int SW        = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_inv,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [R*D_WIDTH-1:0] order,
    output logic [SW-1:0]      stage,
    output logic               busy,
    output logic               done
`ifdef AGU_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int CW = (LOGN > RADIX_LOG) ? LOGN - RADIX_LOG : 1;
    localparam int AW = LOGN + 1;
    localparam logic [SW-1:0] L_LAST = SW'(K - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        i_q, i_d, j_q, j_d;
    logic [SW-1:0]        l_q, l_d;
    logic                 inv_q, inv_d;
    logic                 last_q, last_d;
    logic                 out_valid_q, out_valid_d;
    logic [R*D_WIDTH-1:0] order_q, order_d;
    logic [SW-1:0]        stage_q, stage_d;

    logic [CW-1:0]        i_upper, j_upper;
    logic [AW-1:0]        lane_addr [R];
    logic [SW-1:0]        l_end;
    logic                 load;

    assign load  = !out_valid_q || out_ready;
    assign l_end = inv_q ? '0 : L_LAST;

    // Each stage selects constant shift amounts, so this unrolls to muxes over l.
    always_comb begin
        logic [AW-1:0] rv;
        rv      = '0;
        i_upper = '0;
        j_upper = '0;
        for (int m = 0; m < R; m++) lane_addr[m] = '0;
        for (int k = 0; k < K; k++) begin
            if (l_q == SW'(k)) begin
                rv = '0;
                for (int b = 0; b < RADIX_LOG * k; b++) rv[RADIX_LOG*k-1-b] = j_q[b];
                i_upper = CW'((AW'(1) << (LOGN - RADIX_LOG * (k + 1))) - AW'(1));
                j_upper = CW'((AW'(1) << (RADIX_LOG * k)) - AW'(1));
                for (int m = 0; m < R; m++) begin
                    lane_addr[m] = (rv << (LOGN - RADIX_LOG * k))
                                 + (AW'(m) << (LOGN - RADIX_LOG * (k + 1)))
                                 + AW'(i_q);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        l_d         = l_q;
        inv_d       = inv_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        order_d     = order_q;
        stage_d     = stage_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    inv_d   = mode_inv;
                    l_d     = mode_inv ? L_LAST : '0;
                    i_d     = '0;
                    j_d     = '0;
                    last_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (load) begin
                    // last_q means the final beat is already on the bus and is now taken.
                    if (last_q) begin
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        out_valid_d = 1'b1;
                        stage_d     = l_q;
                        for (int m = 0; m < R; m++) begin
                            order_d[m*D_WIDTH +: D_WIDTH] = D_WIDTH'(lane_addr[m]);
                        end
                        if (i_q == i_upper) begin
                            i_d = '0;
                            if (j_q == j_upper) begin
                                j_d = '0;
                                if (l_q == l_end) last_d = 1'b1;
                                else l_d = inv_q ? l_q - SW'(1) : l_q + SW'(1);
                            end else begin
                                j_d = j_q + CW'(1);
                            end
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            l_q         <= '0;
            inv_q       <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            order_q     <= '0;
            stage_q     <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            l_q         <= l_d;
            inv_q       <= inv_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            order_q     <= order_d;
            stage_q     <= stage_d;
        end
    end

    assign out_valid = out_valid_q;
    assign order     = order_q;
    assign stage     = stage_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

`ifdef AGU_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_agu_param.sv
// Bench for ntt_agu_param: a small LOGN=4/RADIX_LOG=2 instance and a default-parameter instance.
module tb_ntt_agu_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_start, s_inv, s_ready, s_valid, s_busy, s_done;
    logic [31:0] s_order;
    logic [0:0]  s_stage;
    logic        b_start, b_inv, b_ready, b_valid, b_busy, b_done;
    logic [255:0] b_order;
    logic [1:0]  b_stage;
`ifdef AGU_STALL_CNT_EN
    logic [15:0] s_stall, b_stall;
`endif

    ntt_agu_param #(.LOGN(4), .RADIX_LOG(2), .D_WIDTH(8)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .mode_inv(s_inv), .out_ready(s_ready),
        .out_valid(s_valid), .order(s_order), .stage(s_stage), .busy(s_busy), .done(s_done)
`ifdef AGU_STALL_CNT_EN
        , .stall_cnt(s_stall)
`endif
    );

    ntt_agu_param u_big (
        .clk(clk), .rst(rst), .start(b_start), .mode_inv(b_inv), .out_ready(b_ready),
        .out_valid(b_valid), .order(b_order), .stage(b_stage), .busy(b_busy), .done(b_done)
`ifdef AGU_STALL_CNT_EN
        , .stall_cnt(b_stall)
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_l[$], exp_j[$], exp_i[$];
    int tbl [8][4];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rev_bits(int v, int n);
        int r = 0;
        for (int b = 0; b < n; b++) if ((v >> b) & 1) r |= 1 << (n - 1 - b);
        return r;
    endfunction

    function automatic int model_addr(int logn, int rl, int l, int j, int i, int m);
        return rev_bits(j, rl * l) * (1 << (logn - rl * l)) + m * (1 << (logn - rl * (l + 1))) + i;
    endfunction

    // Full expected beat list: stage order, then j outer, i inner.
    task automatic build_seq(input int logn, input int rl, input bit inv);
        int k = logn / rl;
        exp_l.delete(); exp_j.delete(); exp_i.delete();
        for (int s = 0; s < k; s++) begin
            int l = inv ? k - 1 - s : s;
            for (int j = 0; j < (1 << (rl * l)); j++)
                for (int i = 0; i < (1 << (logn - rl * (l + 1))); i++) begin
                    exp_l.push_back(l); exp_j.push_back(j); exp_i.push_back(i);
                end
        end
    endtask

    task automatic sweep_s(input bit inv, input int pct, input bit poke, input int stall_at, input bit use_tbl);
        int cyc = 0, nb = 0, last_acc = -1, first_v = -1, done_cyc = -1, stalls = 0, stall_left = 3;
        bit prev_stall = 0;
        logic [31:0] prev_order = '0;
        logic [0:0]  prev_stage = '0;
        logic [255:0] e;
        build_seq(4, 2, inv);
        @(negedge clk);
        s_inv = inv; s_start = 1'b1; s_ready = 1'b1;
        while (cyc < 2000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            s_start = poke && (cyc == 3 || cyc == 6);
            s_inv   = poke ? ~inv : inv;
            if (cyc == 1) begin
                chk("busy_after_start", s_busy, 1);
                chk("valid_low_cycle1", s_valid, 0);
            end
            if (s_valid && first_v < 0) first_v = cyc;
            if (prev_stall) begin
                chk("hold_order", s_order, prev_order);
                chk("hold_stage", s_stage, prev_stage);
                chk("hold_valid", s_valid, 1);
            end
            if (s_done) begin
                done_cyc = cyc;
                chk("done_valid_low", s_valid, 0);
                chk("done_busy_low", s_busy, 0);
                chk("done_after_last", cyc, last_acc + 1);
            end else begin
                if (stall_at >= 0 && nb == stall_at && s_valid && stall_left > 0) begin
                    s_ready = 1'b0;
                    stall_left--;
                end else begin
                    s_ready = ($urandom_range(0, 99) < pct);
                end
                if (s_valid && !s_ready) stalls++;
                if (s_valid && s_ready) begin
                    if (nb < exp_l.size()) begin
                        e = '0;
                        for (int m = 0; m < 4; m++)
                            e[m*8 +: 8] = 8'(model_addr(4, 2, exp_l[nb], exp_j[nb], exp_i[nb], m));
                        chk("small_order", s_order, e);
                        chk("small_stage", s_stage, exp_l[nb]);
                        if (use_tbl) begin
                            e = '0;
                            for (int m = 0; m < 4; m++) e[m*8 +: 8] = 8'(tbl[inv ? (nb + 4) % 8 : nb][m]);
                            chk("small_order_table", s_order, e);
                        end
                    end else begin
                        chk("extra_beat", nb, exp_l.size());
                    end
                    nb++;
                    last_acc = cyc;
                end
                prev_stall = s_valid && !s_ready;
                prev_order = s_order;
                prev_stage = s_stage;
            end
        end
        s_start = 1'b0; s_ready = 1'b1; s_inv = 1'b0;
        chk("small_done_seen", done_cyc >= 0, 1);
        chk("small_beat_count", nb, 8);
        chk("first_valid_cycle", first_v, 2);
        if (pct == 100 && stall_at < 0) chk("done_cycle", done_cyc, 10);
`ifdef AGU_STALL_CNT_EN
        chk("stall_cnt_at_done", s_stall, stalls);
`endif
        @(negedge clk);
        chk("done_single_pulse", s_done, 0);
        chk("idle_busy_low", s_busy, 0);
`ifdef AGU_STALL_CNT_EN
        chk("stall_cnt_holds", s_stall, stalls);
`endif
    endtask

    initial begin
        int nb, cyc, done_cyc, last_acc;
        logic [255:0] e;
        tbl = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                '{0,1,2,3},  '{8,9,10,11}, '{4,5,6,7},   '{12,13,14,15}};
        s_start = 0; s_inv = 0; s_ready = 1;
        b_start = 0; b_inv = 0; b_ready = 1;
        rst = 1'b1;
        #1;
        chk("rst_valid", s_valid, 0);
        chk("rst_order", s_order, 0);
        chk("rst_stage", s_stage, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_big_valid", b_valid, 0);
        chk("rst_big_order", b_order, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed forward and inverse sweeps against the literal beat table.
        sweep_s(1'b0, 100, 1'b0, -1, 1'b1);
        sweep_s(1'b1, 100, 1'b0, -1, 1'b1);
        // Three-cycle stall on beat {1,5,9,13}.
        sweep_s(1'b0, 100, 1'b0, 1, 1'b1);
        // start pulses while busy must be ignored.
        sweep_s(1'b0, 100, 1'b1, -1, 1'b1);
        // Random back-pressure in both directions.
        for (int r = 0; r < 6; r++) sweep_s(r[0], 30 + 10 * r, r == 3, -1, 1'b0);

        // Reset in the middle of a sweep.
        @(negedge clk);
        s_start = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        nb = 0; cyc = 0;
        while (nb < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_valid) nb++;
        end
        chk("midrst_reached_beat5", nb, 5);
        rst = 1'b1;
        #1;
        chk("midrst_valid", s_valid, 0);
        chk("midrst_order", s_order, 0);
        chk("midrst_stage", s_stage, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_done", s_done, 0);
`ifdef AGU_STALL_CNT_EN
        chk("midrst_stall", s_stall, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        sweep_s(1'b0, 100, 1'b0, -1, 1'b1);

        // Default-parameter instance, full 16384-beat sweep with light back-pressure.
        build_seq(16, 4, 1'b0);
        @(negedge clk);
        b_start = 1'b1;
        nb = 0; cyc = 0; done_cyc = -1; last_acc = -1;
        while (cyc < 40000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            b_start = 1'b0;
            if (b_done) begin
                done_cyc = cyc;
                chk("big_done_after_last", cyc, last_acc + 1);
                chk("big_done_valid_low", b_valid, 0);
            end else begin
                b_ready = ($urandom_range(0, 99) < 90);
                if (b_valid && b_ready) begin
                    if (nb < exp_l.size()) begin
                        e = '0;
                        for (int m = 0; m < 16; m++)
                            e[m*16 +: 16] = 16'(model_addr(16, 4, exp_l[nb], exp_j[nb], exp_i[nb], m));
                        chk("big_order", b_order, e);
                        chk("big_stage", b_stage, exp_l[nb]);
                    end else begin
                        chk("big_extra_beat", nb, exp_l.size());
                    end
                    if (nb == 3 * 4096 + 1) begin
                        e = '0;
                        for (int m = 0; m < 16; m++) e[m*16 +: 16] = 16'h8000 + 16'(m);
                        chk("big_s3_j1", b_order, e);
                    end
                    nb++;
                    last_acc = cyc;
                end
            end
        end
        b_ready = 1'b1;
        chk("big_done_seen", done_cyc >= 0, 1);
        chk("big_beat_count", nb, 16384);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntt_agu_param.md
Name: ntt_agu_param

Overview:
Parametrised NTT/INTT address generation unit producing R = 2^RADIX_LOG butterfly operand addresses per beat for an N = 2^LOGN point transform, stage by stage.
It is the successor of the fixed radix-16 AGU. It generalises point count, radix and lane count. It adds start/done control, valid/ready back-pressure and a reversed-stage mode for the inverse transform.
It sits between the NTT controller and the memory bank/conflict-free address mapper.

Parameters:
LOGN, 16, log2 of transform length N; must be a multiple of RADIX_LOG.
RADIX_LOG, 4, log2 of radix; lanes R = 2^RADIX_LOG; stages K = LOGN/RADIX_LOG.
D_WIDTH, 16, address width per lane; must be >= LOGN.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle request to begin a full K-stage sweep
mode_inv  in  1  sampled at start; 1 = stages issued K-1 down to 0
out_ready  in  1  consumer accepts the current beat
out_valid  out  1  order/stage/group are valid
order  out  R*D_WIDTH  lane m address at [m*D_WIDTH +: D_WIDTH]
stage  out  max(1,$clog2(K))  stage index l of the current beat
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last beat is accepted

Interface:
- Reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: out_valid=0, order=0, stage=0, busy=0, done=0. FSM resets to IDLE. Counters i, j and l reset to 0.
- FSM states:
  - IDLE: on start, latch mode_inv, set l = mode_inv ? K-1 : 0, clear i and j, then go to RUN.
  - RUN: issue beats. After the final beat of the final stage is accepted, go to DONE.
  - DONE: pulse done=1 for one cycle, drop busy, then return to IDLE.
- start is ignored outside IDLE.
- Per stage l:
  - i_upper = 2^(LOGN-RADIX_LOG*(l+1)) - 1.
  - j_upper = 2^(RADIX_LOG*l) - 1.
  - Beats per stage = 2^(LOGN-RADIX_LOG).
  - i is the inner counter and increments every accepted beat. j increments when i wraps. l advances (+1, or -1 when mode_inv) when both i and j wrap.
- Address equation: order[m] = rev(j)*2^(LOGN-RADIX_LOG*l) + m*2^(LOGN-RADIX_LOG*(l+1)) + i.
  - rev(j) is the bit reversal of j over RADIX_LOG*l bits; rev = 0 when l = 0.
  - Arithmetic is computed in LOGN+1 bits and truncated to D_WIDTH. Results never exceed N-1.
  - Shifts are realised as muxes over l; no multipliers.
- Pipelining:
  - Output stage is registered. The first beat appears the cycle after the IDLE→RUN transition, i.e. out_valid rises 2 cycles after start.
  - The output register loads when (!out_valid || out_ready).
  - Counters advance only on that load, so there is no bubble under continuous out_ready.
- Back-pressure: while out_valid && !out_ready, order, stage and out_valid are held stable and counters freeze.
- out_valid drops in the cycle after the last beat is accepted. done asserts in that same cycle.
- Stage K-1 has i_upper=0 and counts only j. Stage 0 has j_upper=0 and counts only i. K=1 is legal: one stage with i only.
- Reset mid-sweep: returns immediately to IDLE with reset values. The sweep is not resumed.

Optional Feature:
- Macro: AGU_STALL_CNT_EN.
- With the macro: adds output stall_cnt [15:0].
  - stall_cnt counts cycles with out_valid && !out_ready and saturates at 16'hFFFF.
  - It is cleared on an accepted start and holds its value after done.
  - It resets to 0.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- LOGN=4, RADIX_LOG=2, mode_inv=0, out_ready=1: start at cycle 0 → out_valid from cycle 2 for 8 consecutive beats.
  - Stage 0 beats: {0,4,8,12}, {1,5,9,13}, {2,6,10,14}, {3,7,11,15}.
  - Stage 1 beats: {0,1,2,3}, {8,9,10,11}, {4,5,6,7}, {12,13,14,15}.
  - done pulses at cycle 10.
- Same config, mode_inv=1 → the stage 1 beat sequence is issued first, then stage 0; stage output reads 1 then 0; total 8 beats.
- Same config, out_ready low for 3 cycles while beat {1,5,9,13} is presented → bus held stable for 3 cycles, next beat {2,6,10,14}, no beat lost or duplicated; with AGU_STALL_CNT_EN, stall_cnt=3 at done.
- Default params (LOGN=16, RADIX_LOG=4): 4 stages × 4096 beats = 16384 beats. Stage 3, j=1 gives {0x8000..0x800F}. done after the 16384th accept.
- rst asserted at beat 5 of a sweep → all outputs 0 immediately. A new start produces beat {0,4,8,12} again.
- start pulsed while busy → ignored; the beat sequence is unchanged and a single done is produced.
